// File: rtl/iob_mem_arbiter.sv
// Two-requester arbiter sharing one single-port IOb memory: latches the winning
// request, issues one memory pulse, and answers the owner with a one-cycle ready.
module iob_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                r0_valid_i,
  input  logic [ADDR_W-1:0]   r0_addr_i,
  input  logic [DATA_W-1:0]   r0_wdata_i,
  input  logic [DATA_W/8-1:0] r0_wstrb_i,
  output logic [DATA_W-1:0]   r0_rdata_o,
  output logic                r0_ready_o,
  input  logic                r1_valid_i,
  input  logic [ADDR_W-1:0]   r1_addr_i,
  input  logic [DATA_W-1:0]   r1_wdata_i,
  input  logic [DATA_W/8-1:0] r1_wstrb_i,
  output logic [DATA_W-1:0]   r1_rdata_o,
  output logic                r1_ready_o,
  output logic                mem_valid_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_ready_i,
  output logic [1:0]          grant_o,
  output logic                busy_o
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic              last_grant_q, last_grant_d;
  logic [1:0]        grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              mem_valid_q, mem_valid_d;
  logic              r0_ready_q, r0_ready_d;
  logic              r1_ready_q, r1_ready_d;
  logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
  logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;
  logic              req_any;
  logic              win_port;

  // Winner selection: on contention, round-robin away from the last owner or fixed port 0.
  always_comb begin
    req_any  = r0_valid_i | r1_valid_i;
    win_port = 1'b0;
    if (r0_valid_i && r1_valid_i) begin
      win_port = RR_EN ? ~last_grant_q : 1'b0;
    end else if (r1_valid_i) begin
      win_port = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_any) state_d = S_ISSUE;
      S_ISSUE: state_d = mem_ready_i ? S_RESP : S_WAIT;
      S_WAIT:  if (mem_ready_i) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; ready/rdata land on the edge into RESP.
  always_comb begin
    req_d        = req_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mem_valid_d  = 1'b0;
    r0_ready_d   = 1'b0;
    r1_ready_d   = 1'b0;
    r0_rdata_d   = r0_rdata_q;
    r1_rdata_d   = r1_rdata_q;
    busy_d       = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          mem_valid_d  = 1'b1;
          last_grant_d = win_port;
          grant_d      = win_port ? 2'b10 : 2'b01;
          req_d        = win_port ? req_t'{r1_addr_i, r1_wdata_i, r1_wstrb_i}
                                  : req_t'{r0_addr_i, r0_wdata_i, r0_wstrb_i};
        end
      end
      S_ISSUE, S_WAIT: begin
        if (mem_ready_i) begin
          r0_ready_d = grant_q[0];
          r1_ready_d = grant_q[1];
          if (grant_q[0]) r0_rdata_d = mem_rdata_i;
          if (grant_q[1]) r1_rdata_d = mem_rdata_i;
        end
      end
      S_RESP:  grant_d = 2'b00;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      req_q        <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 2'b00;
      busy_q       <= 1'b0;
      mem_valid_q  <= 1'b0;
      r0_ready_q   <= 1'b0;
      r1_ready_q   <= 1'b0;
      r0_rdata_q   <= '0;
      r1_rdata_q   <= '0;
    end else begin
      req_q        <= req_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      mem_valid_q  <= mem_valid_d;
      r0_ready_q   <= r0_ready_d;
      r1_ready_q   <= r1_ready_d;
      r0_rdata_q   <= r0_rdata_d;
      r1_rdata_q   <= r1_rdata_d;
    end
  end

  assign mem_valid_o = mem_valid_q;
  assign mem_addr_o  = req_q.addr;
  assign mem_wdata_o = req_q.wdata;
  assign mem_wstrb_o = req_q.wstrb;
  assign r0_ready_o  = r0_ready_q;
  assign r1_ready_o  = r1_ready_q;
  assign r0_rdata_o  = r0_rdata_q;
  assign r1_rdata_o  = r1_rdata_q;
  assign grant_o     = grant_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_iob_mem_arbiter.sv
// Directed bench for iob_mem_arbiter: instance a (round-robin) with a latency-programmable
// memory model, instance b (fixed priority) with a plain one-cycle memory.
module tb_iob_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // instance a signals
  logic        r0_valid, r1_valid, r0_ready, r1_ready;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata, r0_rdata, r1_rdata;
  logic [3:0]  r0_wstrb, r1_wstrb;
  logic        mem_valid, mem_ready, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  grant;

  // instance b signals
  logic        b_r0_valid, b_r1_valid, b_r0_ready, b_r1_ready;
  logic [31:0] b_r0_rdata, b_r1_rdata;
  logic        b_mem_valid, b_mem_ready, b_busy;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_wstrb;
  logic [1:0]  b_grant;

  iob_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b1)) u_dut_a (
    .clk_i(clk), .arst_n_i(rst_n),
    .r0_valid_i(r0_valid), .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata), .r0_wstrb_i(r0_wstrb),
    .r0_rdata_o(r0_rdata), .r0_ready_o(r0_ready),
    .r1_valid_i(r1_valid), .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata), .r1_wstrb_i(r1_wstrb),
    .r1_rdata_o(r1_rdata), .r1_ready_o(r1_ready),
    .mem_valid_o(mem_valid), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_wstrb_o(mem_wstrb), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
    .grant_o(grant), .busy_o(busy)
  );

  iob_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b0)) u_dut_b (
    .clk_i(clk), .arst_n_i(rst_n),
    .r0_valid_i(b_r0_valid), .r0_addr_i(32'h0), .r0_wdata_i(32'h0), .r0_wstrb_i(4'h0),
    .r0_rdata_o(b_r0_rdata), .r0_ready_o(b_r0_ready),
    .r1_valid_i(b_r1_valid), .r1_addr_i(32'h4), .r1_wdata_i(32'h0), .r1_wstrb_i(4'h0),
    .r1_rdata_o(b_r1_rdata), .r1_ready_o(b_r1_ready),
    .mem_valid_o(b_mem_valid), .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
    .mem_wstrb_o(b_mem_wstrb), .mem_rdata_i(b_mem_rdata), .mem_ready_i(b_mem_ready),
    .grant_o(b_grant), .busy_o(b_busy)
  );

  // Memory model for a: lat_cfg 0 = combinational, N = ready N cycles after mem_valid.
  logic [31:0] mem [64];
  int          lat_cfg = 1;
  logic        stray_rdy = 1'b0;
  logic        pend, rdy_reg;
  int          cnt;
  logic [31:0] rd_reg, wmerge;

  always_comb begin
    wmerge = mem[mem_addr[7:2]];
    for (int b = 0; b < 4; b++) if (mem_wstrb[b]) wmerge[8*b +: 8] = mem_wdata[8*b +: 8];
    mem_ready = ((lat_cfg == 0) ? mem_valid : rdy_reg) | stray_rdy;
    mem_rdata = (lat_cfg == 0) ? mem[mem_addr[7:2]] : rd_reg;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      rdy_reg <= 1'b0;
      cnt     <= 0;
    end else begin
      rdy_reg <= 1'b0;
      if (mem_valid) begin
        if (mem_wstrb != 4'h0) mem[mem_addr[7:2]] <= wmerge;
        if (lat_cfg >= 1) begin
          rd_reg <= mem[mem_addr[7:2]];
          if (lat_cfg == 1) rdy_reg <= 1'b1;
          else begin
            pend <= 1'b1;
            cnt  <= lat_cfg - 1;
          end
        end
      end else if (pend) begin
        if (cnt == 1) begin
          rdy_reg <= 1'b1;
          pend    <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    b_mem_ready <= b_mem_valid;
    b_mem_rdata <= 32'h0;
  end

  // Watches port 0 read data for any change while enabled.
  logic        watch_r0 = 1'b0;
  logic [31:0] r0_keep;
  int          r0_changes = 0;
  always @(negedge clk) if (watch_r0 && r0_rdata !== r0_keep) r0_changes++;

  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_wstrb;
  logic [1:0]  snap_grant;

  task automatic txn(input int p, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, output logic [31:0] rd, output int lat,
                     output int nvalid);
    @(posedge clk); #1;
    if (p == 0) begin
      r0_valid = 1'b1; r0_addr = addr; r0_wdata = wdata; r0_wstrb = wstrb;
    end else begin
      r1_valid = 1'b1; r1_addr = addr; r1_wdata = wdata; r1_wstrb = wstrb;
    end
    lat = -1; nvalid = 0; rd = 32'h0;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      @(negedge clk);
      if (mem_valid) begin
        if (nvalid == 0) begin
          snap_addr = mem_addr; snap_wdata = mem_wdata; snap_wstrb = mem_wstrb; snap_grant = grant;
        end
        nvalid++;
      end
      if ((p == 0 && r0_ready) || (p == 1 && r1_ready)) begin
        lat = c;
        rd  = (p == 0) ? r0_rdata : r1_rdata;
      end
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
  endtask

  task automatic pair(output int first, output int second,
                      output logic [1:0] g_first, output logic [1:0] g_second);
    @(posedge clk); #1;
    r0_valid = 1'b1; r0_addr = 32'h40; r0_wstrb = 4'h0;
    r1_valid = 1'b1; r1_addr = 32'h44; r1_wstrb = 4'h0;
    first = -1; second = -1; g_first = 2'b00; g_second = 2'b00;
    for (int c = 0; c < 40 && second < 0; c++) begin
      @(negedge clk);
      if (mem_valid && first < 0 && g_first == 2'b00) g_first = grant;
      if (mem_valid && first >= 0 && g_second == 2'b00) g_second = grant;
      if (r0_ready) begin
        if (first < 0) first = 0; else second = 0;
        r0_valid = 1'b0;
      end
      if (r1_ready) begin
        if (first < 0) first = 1; else second = 1;
        r1_valid = 1'b0;
      end
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({mem_valid, mem_addr, mem_wdata, mem_wstrb, r0_ready, r1_ready, r0_rdata, r1_rdata,
         grant, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_a: got busy=%b grant=%b mem_valid=%b addr=%h expected all zero",
               busy, grant, mem_valid, mem_addr);
    end
    n_cmp++;
    if ({b_mem_valid, b_mem_addr, b_r0_ready, b_r1_ready, b_r0_rdata, b_grant, b_busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_b: got busy=%b grant=%b mem_valid=%b expected all zero",
               b_busy, b_grant, b_mem_valid);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_port0_rw();
    logic [31:0] rd;
    int lat, nv;
    txn(0, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat, nv);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL t1_wr_lat: got %0d expected 3", lat); end
    n_cmp++; if (nv !== 1) begin n_bad++; $display("FAIL t1_wr_nvalid: got %0d expected 1", nv); end
    n_cmp++;
    if ({snap_addr, snap_wdata, snap_wstrb, snap_grant} !== {32'h10, 32'hDEADBEEF, 4'hF, 2'b01}) begin
      n_bad++;
      $display("FAIL t1_wr_issue: got addr=%h wdata=%h wstrb=%h grant=%b expected 10 deadbeef f 01",
               snap_addr, snap_wdata, snap_wstrb, snap_grant);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, grant} !== 3'b000) begin
      n_bad++; $display("FAIL t1_idle_after: got busy=%b grant=%b expected 0 00", busy, grant);
    end
    txn(0, 32'h10, 32'h0, 4'h0, rd, lat, nv);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL t1_rd_data: got %h expected deadbeef", rd); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL t1_rd_lat: got %0d expected 3", lat); end
    n_cmp++; if (nv !== 1) begin n_bad++; $display("FAIL t1_rd_nvalid: got %0d expected 1", nv); end
  endtask

  task automatic test_round_robin();
    int f, s, lat, nv;
    logic [1:0] g1, g2;
    logic [31:0] rd;
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      pair(f, s, g1, g2);
      n_cmp++;
      if (f !== 0 || s !== 1) begin
        n_bad++; $display("FAIL t2_order_pair%0d: got %0d,%0d expected 0,1", k, f, s);
      end
      n_cmp++;
      if (g1 !== 2'b01 || g2 !== 2'b10) begin
        n_bad++; $display("FAIL t2_grant_pair%0d: got %b,%b expected 01,10", k, g1, g2);
      end
    end
    txn(0, 32'h40, 32'h0, 4'h0, rd, lat, nv);
    pair(f, s, g1, g2);
    n_cmp++;
    if (f !== 1 || s !== 0) begin
      n_bad++; $display("FAIL t2_rr_after_p0: got %0d,%0d expected 1,0", f, s);
    end
    n_cmp++;
    if (g1 !== 2'b10) begin n_bad++; $display("FAIL t2_rr_grant: got %b expected 10", g1); end
  endtask

  task automatic test_fixed_priority();
    int r0_done = 0, bad = 0, last_r0 = -1, r1_cyc = -1;
    logic [1:0] g1 = 2'b00;
    @(posedge clk); #1;
    b_r0_valid = 1'b1; b_r1_valid = 1'b1;
    for (int c = 0; c < 100 && r1_cyc < 0; c++) begin
      @(negedge clk);
      if (r0_done < 5 && (b_grant == 2'b10 || b_r1_ready)) bad++;
      if (r0_done == 5 && b_mem_valid) g1 = b_grant;
      if (b_r1_ready) begin r1_cyc = c; b_r1_valid = 1'b0; end
      if (b_r0_ready) begin
        r0_done++;
        if (r0_done == 5) begin b_r0_valid = 1'b0; last_r0 = c; end
      end
    end
    b_r0_valid = 1'b0; b_r1_valid = 1'b0;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL t3_p1_starved: got %0d p1 grants expected 0", bad); end
    n_cmp++; if (r0_done !== 5) begin n_bad++; $display("FAIL t3_p0_count: got %0d expected 5", r0_done); end
    n_cmp++;
    if (r1_cyc - last_r0 !== 4) begin
      n_bad++; $display("FAIL t3_p1_after_stop: got %0d cycles expected 4", r1_cyc - last_r0);
    end
    n_cmp++; if (g1 !== 2'b10) begin n_bad++; $display("FAIL t3_p1_grant: got %b expected 10", g1); end
  endtask

  task automatic test_wait_latency();
    int bad = 0, lat = -1, mr = -1, nv;
    logic [31:0] rd = 32'h0;
    lat_cfg = 5;
    @(posedge clk); #1;
    r0_valid = 1'b1; r0_addr = 32'h10; r0_wstrb = 4'h0;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 6 &&
          (mem_valid !== 1'b0 || busy !== 1'b1 || r0_ready !== 1'b0 || mem_addr !== 32'h10 ||
           mem_wstrb !== 4'h0 || grant !== 2'b01)) bad++;
      if (mem_ready && mr < 0) mr = c;
      if (r0_ready) begin lat = c; rd = r0_rdata; end
    end
    r0_valid = 1'b0;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL t4_wait_stable: got %0d bad cycles expected 0", bad); end
    n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL t4_slow_lat: got %0d expected 7", lat); end
    n_cmp++; if (lat - mr !== 1) begin n_bad++; $display("FAIL t4_ready_after_mem: got %0d expected 1", lat - mr); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL t4_slow_data: got %h expected deadbeef", rd); end
    lat_cfg = 0;
    txn(0, 32'h10, 32'h0, 4'h0, rd, lat, nv);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL t4_comb_lat: got %0d expected 2", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL t4_comb_data: got %h expected deadbeef", rd); end
    lat_cfg = 1;
  endtask

  task automatic test_reset_mid();
    int lat, nv, stray_bad = 0;
    logic [31:0] rd;
    lat_cfg = 10;
    @(posedge clk); #1;
    r0_valid = 1'b1; r0_addr = 32'h10; r0_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t5_busy_wait: got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    r0_valid = 1'b0;
    #1;
    n_cmp++;
    if ({mem_valid, mem_addr, mem_wdata, mem_wstrb, r0_ready, r1_ready, r0_rdata, r1_rdata,
         grant, busy} !== '0) begin
      n_bad++;
      $display("FAIL t5_async_clear: got busy=%b grant=%b mem_valid=%b addr=%h expected all zero",
               busy, grant, mem_valid, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    lat_cfg = 1;
    txn(1, 32'h10, 32'h0, 4'h0, rd, lat, nv);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL t5_post_lat: got %0d expected 3", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL t5_post_data: got %h expected deadbeef", rd); end
    @(posedge clk); #1;
    stray_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) stray_rdy = 1'b0;
      if (r0_ready || r1_ready || busy) stray_bad++;
    end
    n_cmp++; if (stray_bad !== 0) begin n_bad++; $display("FAIL t5_stray_ready: got %0d bad cycles expected 0", stray_bad); end
  endtask

  task automatic test_partial_write();
    int lat, nv;
    logic [31:0] rd;
    txn(0, 32'h10, 32'h0, 4'h0, rd, lat, nv);
    r0_keep = 32'hDEADBEEF;
    watch_r0 = 1'b1;
    txn(1, 32'h20, 32'h11223344, 4'hF, rd, lat, nv);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL t6_full_wr_lat: got %0d expected 3", lat); end
    txn(1, 32'h20, 32'hAAAA5555, 4'h3, rd, lat, nv);
    n_cmp++; if (snap_wstrb !== 4'h3) begin n_bad++; $display("FAIL t6_wstrb: got %h expected 3", snap_wstrb); end
    txn(1, 32'h20, 32'h0, 4'h0, rd, lat, nv);
    n_cmp++; if (rd !== 32'h11225555) begin n_bad++; $display("FAIL t6_merge: got %h expected 11225555", rd); end
    watch_r0 = 1'b0;
    n_cmp++; if (r0_changes !== 0) begin n_bad++; $display("FAIL t6_r0_rdata_held: got %0d changes expected 0", r0_changes); end
  endtask

  initial begin
    rst_n = 1'b0;
    r0_valid = 1'b0; r0_addr = 32'h0; r0_wdata = 32'h0; r0_wstrb = 4'h0;
    r1_valid = 1'b0; r1_addr = 32'h0; r1_wdata = 32'h0; r1_wstrb = 4'h0;
    b_r0_valid = 1'b0; b_r1_valid = 1'b0;
    test_reset();
    test_port0_rw();
    test_round_robin();
    test_fixed_priority();
    test_wait_latency();
    test_reset_mid();
    test_partial_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
